// File: rtl/memory_stage.sv
// memory_stage: fourth stage of the five-stage ECE350 pipeline.
//
// Latches the execute-stage bundle, performs lw/sw accesses over a
// request/ready handshake with variable latency, freezes the front of the
// pipeline while an access is outstanding, and hands a registered
// instruction/result pair to writeback together with forwarding info.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   insnIn              instruction from execute
//   dataExecIn          ALU result or lw/sw effective address
//   rdIn                store data (rt value)
//   dmemReady           memory completed the current request
//   dmemDataIn          load data from memory
//   dmemReq, dmemWe     access request / write enable
//   dmemAddr            word address (ADDR_W bits)
//   dmemDataOut         store data
//   stall               freeze PC, fetch, decode and execute latches
//   insnOut, dataMemOut registered instruction/result to writeback
//   bypassValid/Reg/Data forwarding info for the held instruction
//   memError            sticky access-timeout flag
module memory_stage #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       insnIn,
  input  logic [31:0]       dataExecIn,
  input  logic [31:0]       rdIn,
  input  logic              dmemReady,
  input  logic [31:0]       dmemDataIn,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [31:0]       dmemDataOut,
  output logic              stall,
  output logic [31:0]       insnOut,
  output logic [31:0]       dataMemOut,
  output logic              bypassValid,
  output logic [4:0]        bypassReg,
  output logic [31:0]       bypassData,
  output logic              memError
);

  localparam logic [4:0]  OP_RTYPE = 5'b00000;
  localparam logic [4:0]  OP_ADDI  = 5'b00101;
  localparam logic [4:0]  OP_SETX  = 5'b10101;
  localparam logic [4:0]  OP_JAL   = 5'b00011;
  localparam logic [4:0]  OP_LW    = 5'b01000;
  localparam logic [4:0]  OP_SW    = 5'b00111;
  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
  // Aborted accesses are replaced by "addi $30, 6" so software sees a status code.
  localparam logic [31:0] ABORT_INSN = 32'h2F80_0000;
  localparam logic [31:0] ABORT_DATA = 32'd6;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [31:0] insnLatch_q, addrLatch_q, storeLatch_q;
  logic [31:0] insnOut_q, insnOut_d;
  logic [31:0] dataOut_q, dataOut_d;
  logic        memError_q, memError_d;

  logic [4:0]  opcode;
  logic        isLw, isSw, isMem, isJal, writesReg;
  logic        memReq, stallInt, complete, abort;

  // Decode of the held instruction.
  assign opcode    = insnLatch_q[31:27];
  assign isLw      = (opcode == OP_LW);
  assign isSw      = (opcode == OP_SW);
  assign isMem     = isLw | isSw;
  assign isJal     = (opcode == OP_JAL);
  assign writesReg = isLw | isJal | (opcode == OP_RTYPE) |
                     (opcode == OP_ADDI) | (opcode == OP_SETX);

  // Memory interface driven straight from the latch so it is stable while the request is held.
  assign dmemReq     = memReq;
  assign dmemWe      = isSw & memReq;
  assign dmemAddr    = addrLatch_q[ADDR_W-1:0];
  assign dmemDataOut = storeLatch_q;
  assign stall       = stallInt;

  // Forwarding info; lw data is not known yet so it never bypasses from here.
  assign bypassReg   = isJal ? 5'd31 : insnLatch_q[26:22];
  assign bypassValid = writesReg & (bypassReg != 5'd0) & ~isLw;
  assign bypassData  = addrLatch_q;

  assign insnOut    = insnOut_q;
  assign dataMemOut = dataOut_q;
  assign memError   = memError_q;

  // Input latch: follows execute unless the stage is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      insnLatch_q  <= 32'd0;
      addrLatch_q  <= 32'd0;
      storeLatch_q <= 32'd0;
    end else if (!stallInt) begin
      insnLatch_q  <= insnIn;
      addrLatch_q  <= dataExecIn;
      storeLatch_q <= rdIn;
    end
  end

  // Access FSM: a memory op first requests in IDLE; only a miss there moves to WAIT.
  // waitCnt counts request cycles already spent, so the abort lands on request MAX_WAIT+1.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memReq    = 1'b0;
    stallInt  = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (isMem) begin
          memReq = 1'b1;
          if (dmemReady) begin
            complete = 1'b1;
          end else begin
            stallInt  = 1'b1;
            state_d   = ST_WAIT;
            waitCnt_d = 8'd1;
          end
        end
      end
      ST_WAIT: begin
        memReq = 1'b1;
        if (dmemReady) begin
          complete  = 1'b1;
          state_d   = ST_IDLE;
          waitCnt_d = 8'd0;
        end else if (waitCnt_q == MAX_WAIT_C) begin
          abort     = 1'b1;
          state_d   = ST_IDLE;
          waitCnt_d = 8'd0;
        end else begin
          stallInt  = 1'b1;
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writeback result selection; a ready in the timeout cycle wins because abort requires !dmemReady.
  always_comb begin
    insnOut_d  = insnLatch_q;
    dataOut_d  = addrLatch_q;
    memError_d = memError_q;
    if (abort) begin
      insnOut_d  = ABORT_INSN;
      dataOut_d  = ABORT_DATA;
      memError_d = 1'b1;
    end else if (stallInt) begin
      insnOut_d = 32'd0;
      dataOut_d = 32'd0;
    end else if (complete) begin
      if (isLw && insnLatch_q[26:22] != 5'd0) begin
        dataOut_d = dmemDataIn;
      end else begin
        dataOut_d = 32'd0;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      waitCnt_q  <= 8'd0;
      insnOut_q  <= 32'd0;
      dataOut_q  <= 32'd0;
      memError_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      insnOut_q  <= insnOut_d;
      dataOut_q  <= dataOut_d;
      memError_q <= memError_d;
    end
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage of the five-stage ECE350 core. It consumes the execute stage's output bundle: the instruction word, the ALU result / effective address, and the store data. It performs data-memory loads and stores over a request/ready handshake with variable latency, and stalls the front of the pipeline while an access is outstanding. It presents a registered instruction/result pair to writeback, plus bypass information for forwarding.

## Interface
Parameters
- ADDR_W, 12, data-memory word-address width
- MAX_WAIT, 255, maximum wait cycles for dmemReady before an access is aborted (1..255)

Ports
- clock  in  1  pipeline clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset for the whole block
- insnIn  in  32  instruction from execute stage
- dataExecIn  in  32  ALU result, or effective address for lw/sw
- rdIn  in  32  store data (rt value) from execute stage
- dmemReady  in  1  memory has completed the current request (read data valid when high)
- dmemDataIn  in  32  load data from memory
- dmemReq  out  1  access request
- dmemWe  out  1  write enable (sw)
- dmemAddr  out  ADDR_W  word address
- dmemDataOut  out  32  store data
- stall  out  1  freeze PC, fetch, decode and execute latches
- insnOut  out  32  instruction to writeback
- dataMemOut  out  32  result to writeback
- bypassValid  out  1  the held instruction writes a register this cycle
- bypassReg  out  5  destination register of the held instruction
- bypassData  out  32  ALU result of the held instruction (not valid for lw)
- memError  out  1  sticky flag: at least one access timed out

## Operation
- Input latch (insnR, addrR, storeR): loads insnIn/dataExecIn/rdIn on every edge where stall=0. Holds while stall=1. Reset clears it to 0 (nop).
- Decode of insnR[31:27]:
  - lw = 01000 (memory op, register write)
  - sw = 00111 (memory op, no register write)
  - R-type 00000 / addi 00101 / setx 10101 / jal 00011 write registers
  - all other opcodes are pass-through with no register write.
- Memory outputs come from the latch, combinationally:
  - dmemAddr = addrR[ADDR_W-1:0]
  - dmemDataOut = storeR
  - dmemWe = (op==sw) & dmemReq
- FSM with two states, IDLE and WAIT; reset puts it in IDLE.
  - IDLE, non-memory op: dmemReq=0, stall=0.
  - IDLE, memory op: dmemReq=1. If dmemReady=1, the access completes this cycle, stall=0 and the state stays IDLE. Otherwise stall=1 → WAIT, and waitCnt is set to 1.
  - WAIT: dmemReq=1.
    - dmemReady=1 → complete, stall=0 → IDLE.
    - Else if waitCnt==MAX_WAIT → abort, stall=0 → IDLE.
    - Else waitCnt+1 and stall=1.
- Output register (insnOut, dataMemOut) loads every edge:
  - Completed lw: insnR, dmemDataIn.
  - Completed sw: insnR, 0.
  - Non-memory op: insnR, addrR.
  - Stalled cycle: 0, 0 (bubble).
  - Aborted access: 32'b00101111100000000000000000000000 (addi $30 status write), with dataMemOut=6, and memError is set.
- Register $0 rule: if insnR[26:22]==0 and the op is lw, dataMemOut=0.
- Bypass outputs (combinational from the latch):
  - bypassReg = insnR[26:22] (31 for jal)
  - bypassValid = register-writing op & bypassReg≠0 & op≠lw
  - bypassData = addrR
- memError is cleared only by reset.

## Timing
- Reset values: insnOut=0, dataMemOut=0, dmemReq=0, dmemWe=0, stall=0, bypassValid=0, memError=0, state=IDLE, waitCnt=0. dmemAddr and dmemDataOut read 0, because the latch is cleared.
- Latency:
  - Non-memory op: one cycle from latch to insnOut.
  - Zero-wait memory op: one cycle.
  - k-wait memory op: k+1 cycles, with k bubbles emitted.
- dmemAddr, dmemDataOut and dmemWe are stable for the whole time dmemReq=1. The request drops in the cycle after completion unless the next latched instruction is also a memory op. Back-to-back memory ops therefore keep dmemReq high, with a new address.
- A sw is committed exactly once, in the cycle where dmemReq=1 and dmemReady=1. If dmemReady arrives in the same cycle as the timeout, it wins and the access completes normally.
- dmemReady while dmemReq=0 is ignored.
- Reset during WAIT: the next cycle is IDLE with dmemReq=0 and a nop latched. The pending store is dropped.
- stall is combinational from state, the latched op and dmemReady. It has no combinational path from insnIn.

## Test plan
- Reset, then addi $5 with dataExecIn=0x1234 → the next cycle gives insnOut=insn, dataMemOut=0x1234, bypassValid=1, bypassReg=5. All outputs were 0 during reset.
- lw $3, addr=0x010, with dmemReady held high and dmemDataIn=0xCAFEF00D → dmemReq=1 and dmemAddr=0x010 for one cycle, no stall, then dataMemOut=0xCAFEF00D.
- sw, addr=0x020, rdIn=0x55, with dmemReady delayed 3 cycles → stall=1 for exactly 3 cycles, 3 bubbles (insnOut=0), dmemWe=1 throughout, exactly one write of 0x55.
- MAX_WAIT=4 with dmemReady never asserted → the abort happens on the 5th request cycle: insnOut=0x2F800000, dataMemOut=6, memError=1 stays set, stall drops.
- lw followed by sw back-to-back, both zero-wait → dmemReq stays high for 2 cycles, the addresses change on the edge, and there are no bubbles.
- Reset asserted in cycle 2 of a WAIT → the next cycle has dmemReq=0, stall=0, insnOut=0, and the store is never written.
